// File: rtl/riscv_dmem.sv
// riscv_dmem: data-memory responder for the RISC-V Lite core.
// Byte addresses are decoded into a word array. Stores take effect on the
// clock edge. Loads return registered data one cycle after the request.
// Illegal accesses set a sticky error flag and latch the first bad address.
// A preload port initialises contents independently of the core bus.
module riscv_dmem #(
  parameter int              NBIT      = 32,
  parameter int              DEPTH     = 64,
  parameter logic [NBIT-1:0] BASE_ADDR = 32'h1001_0000,
  parameter int              CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBIT-1:0]          address_dm,
  input  logic [NBIT-1:0]          data_to_mem,
  input  logic                     read_mem,
  input  logic                     write_mem,
  output logic [NBIT-1:0]          data_from_mem,
  input  logic                     init_en,
  input  logic [$clog2(DEPTH)-1:0] init_idx,
  input  logic [NBIT-1:0]          init_data,
  output logic                     err,
  output logic [NBIT-1:0]          err_addr,
  output logic [CNT_W-1:0]         rd_count,
  output logic [CNT_W-1:0]         wr_count
);

  localparam int              IW      = $clog2(DEPTH);
  localparam logic [NBIT-1:0] DEPTH_N = NBIT'(DEPTH);
  localparam logic [IW:0]     DEPTH_W = (IW+1)'(DEPTH);

  logic [NBIT-1:0] mem [DEPTH];

  logic [NBIT-1:0] off;
  logic [NBIT-1:0] idx_full;
  logic [IW-1:0]   idx;
  logic            legal;
  logic            rd_ok;
  logic            wr_ok;
  logic            bad;
  logic            init_ok;
  logic            init_hit;

  // Address decode. The request strobes gate everything, so an unknown
  // address on an idle bus cannot leak into state.
  always_comb begin
    off      = address_dm - BASE_ADDR;
    idx_full = off >> 2;
    idx      = idx_full[IW-1:0];
    legal    = (address_dm >= BASE_ADDR) && (off[1:0] == 2'b00) &&
               (idx_full < DEPTH_N);
    rd_ok    = read_mem && legal;
    wr_ok    = write_mem && legal;
    bad      = (read_mem || write_mem) && !legal;
    init_ok  = init_en && ({1'b0, init_idx} < DEPTH_W);
    init_hit = init_ok && (init_idx == idx);
  end

  // Word array: the preload takes priority over a core store to the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok && !init_hit) mem[idx] <= data_to_mem;
      if (init_ok)            mem[init_idx] <= init_data;
    end
  end

  // Load data, error capture and saturating access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_from_mem <= '0;
      err           <= 1'b0;
      err_addr      <= '0;
      rd_count      <= '0;
      wr_count      <= '0;
    end else begin
      // Write-first: same-cycle preload beats core store beats array contents.
      if (rd_ok) begin
        if (init_hit)   data_from_mem <= init_data;
        else if (wr_ok) data_from_mem <= data_to_mem;
        else            data_from_mem <= mem[idx];
      end else if (read_mem) begin
        data_from_mem <= '0;
      end
      if (bad) begin
        err <= 1'b1;
        if (!err) err_addr <= address_dm;
      end
      if (rd_ok && (rd_count != {CNT_W{1'b1}})) rd_count <= rd_count + 1'b1;
      if (wr_ok && (wr_count != {CNT_W{1'b1}})) wr_count <= wr_count + 1'b1;
    end
  end

endmodule
